// File: rtl/rab_lookup_arbiter.sv
// rab_lookup_arbiter: round-robin share of one RAB slice lookup engine.
// Ports: s_axi_aclk/s_axi_aresetn; req_* requester side (valid, addr,
// len, size, type, id, sent -> accept, drop, out_addr); lk_* shared
// lookup engine; int_*/miss_addr/miss_id fault report; busy.
module rab_lookup_arbiter #(
  parameter int N_REQ          = 4,
  parameter int RAB_ENTRIES    = 16,
  parameter int C_AXI_ID_WIDTH = 8,
  parameter int LOOKUP_CYCLES  = 1,
  parameter int REQ_IDX_W      = 2
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*32-1:0]           req_addr,
  input  logic [N_REQ*8-1:0]            req_len,
  input  logic [N_REQ*3-1:0]            req_size,
  input  logic [N_REQ-1:0]              req_type,
  input  logic [N_REQ*C_AXI_ID_WIDTH-1:0] req_id,
  input  logic [N_REQ-1:0]              req_sent,
  output logic [N_REQ-1:0]              req_accept,
  output logic [N_REQ-1:0]              req_drop,
  output logic [31:0]                   req_out_addr,
  output logic [31:0]                   lk_addr_min,
  output logic [31:0]                   lk_addr_max,
  output logic                          lk_rw,
  input  logic [RAB_ENTRIES-1:0]        lk_hit,
  input  logic [RAB_ENTRIES-1:0]        lk_prot,
  input  logic                          lk_multi,
  input  logic [31:0]                   lk_out_addr,
  output logic                          int_miss,
  output logic                          int_prot,
  output logic                          int_multi,
  output logic [31:0]                   miss_addr,
  output logic [REQ_IDX_W+C_AXI_ID_WIDTH-1:0] miss_id,
  output logic                          busy
);

  localparam int IW = C_AXI_ID_WIDTH;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic [1:0] WAIT_SENT = 2'd3;

  localparam logic [1:0] CNT_INIT = 2'(LOOKUP_CYCLES - 1);

  logic [1:0]           state;
  logic [1:0]           cnt;
  logic [REQ_IDX_W-1:0] ptr;
  logic [REQ_IDX_W-1:0] g_q;
  logic [31:0]          addr_q;
  logic [31:0]          max_q;
  logic                 type_q;
  logic [IW-1:0]        id_q;
  logic                 acc_q;

  logic [REQ_IDX_W-1:0] gnt;
  logic [REQ_IDX_W-1:0] ptr_nxt;
  logic                 gnt_vld;
  logic [31:0]          sel_addr;
  logic [31:0]          sel_max;
  logic [7:0]           sel_len;
  logic [2:0]           sel_size;
  logic [15:0]          nbytes;
  logic [N_REQ-1:0]     g_oh;

  logic hit_any;
  logic ok_any;
  logic wrap;
  logic d_multi;
  logic d_miss;
  logic d_prot;
  logic d_acc;

  // Scan from the highest offset down so the lowest offset
  // from ptr (first set bit at/after ptr) wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin : scan
      int k;
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req_valid[k]) begin
        gnt     = REQ_IDX_W'(k);
        gnt_vld = 1'b1;
      end
    end
  end

  assign ptr_nxt  = (gnt == REQ_IDX_W'(N_REQ - 1)) ?
                    '0 : gnt + 1'b1;
  assign sel_addr = req_addr[gnt*32 +: 32];
  assign sel_len  = req_len[gnt*8 +: 8];
  assign sel_size = req_size[gnt*3 +: 3];
  // Burst byte count is deliberately truncated to 16 bits.
  assign nbytes   = (16'(sel_len) + 16'd1) << sel_size;
  assign sel_max  = sel_addr + 32'(nbytes) - 32'd1;

  assign g_oh = {{(N_REQ-1){1'b0}}, 1'b1} << g_q;

  assign hit_any = |lk_hit;
  assign ok_any  = |(lk_hit & lk_prot);
  assign wrap    = max_q < addr_q;
  assign d_multi = lk_multi;
  assign d_miss  = !lk_multi && (!hit_any || wrap);
  assign d_prot  = !lk_multi && hit_any && !wrap && !ok_any;
  assign d_acc   = !lk_multi && hit_any && !wrap && ok_any;

  assign lk_addr_min = (state == LOOKUP) ? addr_q : '0;
  assign lk_addr_max = (state == LOOKUP) ? max_q : '0;
  assign lk_rw       = (state == LOOKUP) && type_q;
  assign busy        = state != IDLE;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      g_q          <= '0;
      addr_q       <= '0;
      max_q        <= '0;
      type_q       <= 1'b0;
      id_q         <= '0;
      acc_q        <= 1'b0;
      req_accept   <= '0;
      req_drop     <= '0;
      req_out_addr <= '0;
      int_miss     <= 1'b0;
      int_prot     <= 1'b0;
      int_multi    <= 1'b0;
      miss_addr    <= '0;
      miss_id      <= '0;
    end else begin
      req_accept <= '0;
      req_drop   <= '0;
      int_miss   <= 1'b0;
      int_prot   <= 1'b0;
      int_multi  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            g_q    <= gnt;
            addr_q <= sel_addr;
            max_q  <= sel_max;
            type_q <= req_type[gnt];
            id_q   <= req_id[gnt*IW +: IW];
            ptr    <= ptr_nxt;
            cnt    <= CNT_INIT;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!req_valid[g_q]) begin
            state <= IDLE;
          end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
          end else begin
            state     <= RESP;
            acc_q     <= d_acc;
            int_multi <= d_multi;
            int_miss  <= d_miss;
            int_prot  <= d_prot;
            if (d_acc) begin
              req_accept   <= g_oh;
              req_out_addr <= lk_out_addr;
            end else begin
              req_drop  <= g_oh;
              miss_addr <= addr_q;
              miss_id   <= {g_q, id_q};
            end
          end
        end
        RESP: begin
          state <= acc_q ? WAIT_SENT : IDLE;
        end
        WAIT_SENT: begin
          if (req_sent[g_q]) begin
            state        <= IDLE;
            req_out_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
